// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
// The fetch buffer stores {pc, instr} pairs as a single packed entry.
package instr_fetch_pkg;

  localparam logic [31:0] IMEM_BASE       = 32'h0100_0000;
  localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
  localparam int          FETCH_BUF_DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Clearing the low bits with a mask keeps every input bit referenced.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_fetch_buffer.sv
// Two-entry FIFO of {pc, instr} pairs between fetch and decode.
// ent0 is always the head, so decode outputs come straight from a register.
module fetch_buffer
  import instr_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t ent0, ent1;
  logic [1:0]   cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= push_entry;
          else             ent1 <= push_entry;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: the new entry lands behind whatever remains.
          if (cnt == 2'd2) begin
            ent0 <= ent1;
            ent1 <= push_entry;
          end else begin
            ent0 <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

  assign count = cnt;
  assign head  = ent0;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC generation, one-deep read tracking against a
// 1-cycle ROM, redirect flush, and a 2-entry buffer feeding decode.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IMEM_BASE
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_rd,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  logic [31:0]  fetch_pc;
  logic         inflight;
  logic [31:0]  inflight_pc;
  logic         kill;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t rsp;
  logic         pop;
  logic         push;
  logic         issue;
  logic [2:0]   occ;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;

  // Credit: buffered + in-flight after this cycle's pop must leave a free slot.
  assign occ   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue = !rst && !redirect_valid && (occ < 3'(FETCH_BUF_DEPTH));

  assign imem_rd   = issue;
  assign imem_addr = fetch_pc;

  assign push      = inflight && !kill && !redirect_valid;
  assign rsp.pc    = inflight_pc;
  assign rsp.instr = imem_instr;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'd0;
      kill        <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= word_align(redirect_pc);
      inflight <= 1'b0;
      kill     <= inflight;
    end else begin
      kill     <= 1'b0;
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + 32'd4;
        inflight_pc <= fetch_pc;
      end
    end
  end

  fetch_buffer u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (rsp),
    .pop        (pop && !redirect_valid),
    .flush      (redirect_valid),
    .count      (count),
    .head       (head)
  );

  assign out_pc    = head.pc;
  assign out_instr = head.instr;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations, then
// randomized traffic, all compared each cycle against a queue-based model.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_rd;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int n_checks = 0;
  int n_err    = 0;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_rd        (imem_rd),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  // Block ROM: word i holds 1000_0000 + i, only [11:2] decoded, holds when idle.
  logic [31:0] rom [1024];
  initial for (int i = 0; i < 1024; i++) rom[i] = 32'h1000_0000 + i;
  always @(posedge clk) if (imem_rd) imem_instr <= rom[imem_addr[11:2]];

  function automatic logic [31:0] memword(input logic [31:0] a);
    return 32'h1000_0000 + ((a >> 2) & 32'h3FF);
  endfunction

  // Reference model: ordered queue of delivered words plus one pending read.
  logic [31:0] q_pc[$];
  logic [31:0] q_in[$];
  logic [31:0] m_fpc   = RST_PC;
  logic        m_pend  = 1'b0;
  logic [31:0] m_ppc   = 32'd0;
  logic        m_kill  = 1'b0;
  logic        m_known = 1'b0;
  logic        m_inrst = 1'b0;

  logic        obs_rd, obs_valid;
  logic [31:0] obs_addr, obs_pc, obs_instr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic rv, input logic [31:0] rp,
                              input logic rdy);
    if (r) begin
      q_pc.delete(); q_in.delete();
      m_fpc = RST_PC; m_pend = 1'b0; m_kill = 1'b0;
      m_inrst = 1'b1; m_known = 1'b1;
    end else begin
      m_inrst = 1'b0;
      if (rv) begin
        q_pc.delete(); q_in.delete();
        m_fpc  = rp & 32'hFFFF_FFFC;
        m_kill = m_pend;
        m_pend = 1'b0;
      end else begin
        bit pp, iss;
        pp  = (q_pc.size() > 0) && rdy;
        iss = (q_pc.size() + int'(m_pend) - int'(pp)) < 2;
        if (pp) begin void'(q_pc.pop_front()); void'(q_in.pop_front()); end
        if (m_pend && !m_kill) begin
          q_pc.push_back(m_ppc);
          q_in.push_back(memword(m_ppc));
        end
        m_kill = 1'b0;
        if (iss) begin
          m_ppc = m_fpc;
          m_fpc = m_fpc + 32'd4;
        end
        m_pend = iss;
      end
    end
  endtask

  // One clock cycle: drive, compare outputs against the model, advance the model.
  task automatic step(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
    logic exp_valid, exp_rd;
    @(negedge clk);
    rst = r; redirect_valid = rv; redirect_pc = rp; out_ready = rdy;
    #1;
    obs_rd = imem_rd; obs_addr = imem_addr; obs_valid = out_valid;
    obs_pc = out_pc;  obs_instr = out_instr;
    if (m_known) begin
      exp_valid = (q_pc.size() > 0);
      exp_rd    = !r && !rv &&
                  ((q_pc.size() + int'(m_pend) - int'(exp_valid && rdy)) < 2);
      chk("model_out_valid", {31'd0, obs_valid}, {31'd0, exp_valid});
      chk("model_imem_rd",   {31'd0, obs_rd},    {31'd0, exp_rd});
      if (!r) chk("model_imem_addr", obs_addr, m_fpc);
      if (exp_valid) begin
        chk("model_out_pc",    obs_pc,    q_pc[0]);
        chk("model_out_instr", obs_instr, q_in[0]);
      end else if (m_inrst) begin
        chk("reset_out_pc",    obs_pc,    32'd0);
        chk("reset_out_instr", obs_instr, 32'd0);
      end
    end
    @(posedge clk);
    model_update(r, rv, rp, rdy);
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, rdy);
  endtask

  initial begin
    repeat (3) step(1'b1, 1'b0, 32'd0, 1'b1);

    // Reset release with decode always ready.
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("rel_rd",   {31'd0, obs_rd}, 32'd1);
    chk("rel_addr", obs_addr, 32'h0100_0000);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("rel_c1_valid", {31'd0, obs_valid}, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("rel_c2_pc",    obs_pc,    32'h0100_0000);
    chk("rel_c2_instr", obs_instr, 32'h1000_0000);

    // Five stall cycles.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 32'd0, 1'b0);
      if (i == 1) begin
        chk("stall_rd_off", {31'd0, obs_rd}, 32'd0);
        chk("stall_hold_pc", obs_pc, 32'h0100_0004);
      end
    end
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("resume_rd", {31'd0, obs_rd}, 32'd1);
    chk("resume_pc", obs_pc, 32'h0100_0004);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("resume_pc1", obs_pc, 32'h0100_0008);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("resume_pc2", obs_pc, 32'h0100_000C);
    run(3, 1'b1);

    // Redirect with one buffered and one in flight.
    step(1'b0, 1'b1, 32'h0100_0203, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("redir_n1_valid", {31'd0, obs_valid}, 32'd0);
    chk("redir_n1_addr",  obs_addr, 32'h0100_0200);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("redir_n2_valid", {31'd0, obs_valid}, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("redir_n3_pc",    obs_pc,    32'h0100_0200);
    chk("redir_n3_instr", obs_instr, 32'h1000_0080);
    run(3, 1'b1);

    // Redirect with pop, then a second redirect right after.
    step(1'b0, 1'b1, 32'h0100_0040, 1'b1);
    step(1'b0, 1'b1, 32'h0100_0080, 1'b1);
    chk("dbl_redir_rd", {31'd0, obs_rd}, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("dbl_n1_addr", obs_addr, 32'h0100_0080);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("dbl_pc",  obs_pc, 32'h0100_0080);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("dbl_pc1", obs_pc, 32'h0100_0084);

    // Reset mid-stream with a full buffer.
    run(2, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    chk("mrst_rd0", {31'd0, obs_rd}, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    chk("mrst_valid", {31'd0, obs_valid}, 32'd0);
    chk("mrst_rd1",   {31'd0, obs_rd}, 32'd0);
    chk("mrst_pc",    obs_pc, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("mrst_addr", obs_addr, RST_PC);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("mrst_first_pc", obs_pc, RST_PC);
    run(2, 1'b1);

    // Address wrap.
    step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("wrap_addr0", obs_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("wrap_addr1", obs_addr, 32'h0000_0000);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("wrap_pc",    obs_pc,    32'hFFFF_FFFC);
    chk("wrap_instr", obs_instr, 32'h1000_03FF);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic r, rv, rdy;
      r   = ($urandom_range(0, 99) == 0);
      rv  = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      step(r, rv, $urandom, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
